// File: rtl/spi_io_expander_n.sv
// SPI mode-0 slave fronting NUM_PORTS 8-bit GPIO ports with direction, output,
// interrupt-enable and sticky W1C interrupt-flag registers and auto-increment bursts.
module spi_io_expander_n #(
    parameter int unsigned NUM_PORTS   = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sck,
    input  logic                   en,
    input  logic                   mosi,
    output logic                   miso,
    input  logic [8*NUM_PORTS-1:0] pin_in,
    output logic [8*NUM_PORTS-1:0] pin_out,
    output logic [8*NUM_PORTS-1:0] pin_oe,
    output logic                   irq
);

    localparam int unsigned PW = 8 * NUM_PORTS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] sckSync;
    logic [SYNC_STAGES-1:0] enSync;
    logic [SYNC_STAGES-1:0] mosiSync;
    logic                   sckDly;
    logic                   enDly;
    logic [PW-1:0]          pinStage [SYNC_STAGES];
    logic [PW-1:0]          pinPrev;

    logic          sckS;
    logic          enS;
    logic          mosiS;
    logic [PW-1:0] pinS;
    logic          sckRise;
    logic          sckFall;
    logic          enRise;
    logic          enFall;

    state_t      state;
    state_t      stateNext;
    logic [2:0]  bitCnt;
    logic [6:0]  rxShift;
    logic [7:0]  txShift;
    logic [5:0]  addr;
    logic        rwFlag;
    logic        aiFlag;

    logic        byteDone;
    logic        wrEn;
    logic [7:0]  wrData;
    logic        txLoad;
    logic        txShiftEn;
    logic [7:0]  rdData;
    logic [2:0]  portSel;
    logic [2:0]  offSel;

    logic [7:0]  dirReg  [NUM_PORTS];
    logic [7:0]  outReg  [NUM_PORTS];
    logic [7:0]  ienReg  [NUM_PORTS];
    logic [7:0]  intfReg [NUM_PORTS];
    logic [7:0]  setEv   [NUM_PORTS];
    logic [7:0]  clrMask [NUM_PORTS];
    logic        intfAny;

    assign sckS    = sckSync[SYNC_STAGES-1];
    assign enS     = enSync[SYNC_STAGES-1];
    assign mosiS   = mosiSync[SYNC_STAGES-1];
    assign pinS    = pinStage[SYNC_STAGES-1];
    assign sckRise = sckS & ~sckDly;
    assign sckFall = ~sckS & sckDly;
    assign enRise  = enS & ~enDly;
    assign enFall  = ~enS & enDly;
    assign portSel = addr[5:3];
    assign offSel  = addr[2:0];
    assign miso    = txShift[7];

    // Input synchronisers, edge-detect delay and previous-pin snapshot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sckSync  <= '0;
            enSync   <= '0;
            mosiSync <= '0;
            sckDly   <= 1'b0;
            enDly    <= 1'b0;
            pinPrev  <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                pinStage[i] <= '0;
            end
        end else begin
            sckSync  <= {sckSync[SYNC_STAGES-2:0], sck};
            enSync   <= {enSync[SYNC_STAGES-2:0], en};
            mosiSync <= {mosiSync[SYNC_STAGES-2:0], mosi};
            sckDly   <= sckS;
            enDly    <= enS;
            pinPrev  <= pinS;
            pinStage[0] <= pin_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                pinStage[i] <= pinStage[i-1];
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // FSM next state and per-clk strobes
    always_comb begin
        stateNext = state;
        byteDone  = 1'b0;
        wrEn      = 1'b0;
        txLoad    = 1'b0;
        txShiftEn = 1'b0;
        wrData    = {rxShift, mosiS};
        if (enFall) begin
            stateNext = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (enRise) stateNext = CMD;
                end
                CMD: begin
                    if (sckRise && bitCnt == 3'd7) begin
                        byteDone  = 1'b1;
                        stateNext = DATA;
                    end
                end
                DATA: begin
                    if (sckRise && bitCnt == 3'd7) begin
                        byteDone = 1'b1;
                        wrEn     = ~rwFlag;
                    end
                    // A falling edge at bit 0 follows a completed byte: fetch next read data
                    if (sckFall && rwFlag) begin
                        if (bitCnt == 3'd0) txLoad    = 1'b1;
                        else                txShiftEn = 1'b1;
                    end
                end
                default: stateNext = IDLE;
            endcase
        end
    end

    // Serial shift path, command latch and address stepping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bitCnt  <= 3'd0;
            rxShift <= 7'd0;
            txShift <= 8'd0;
            addr    <= 6'd0;
            rwFlag  <= 1'b0;
            aiFlag  <= 1'b0;
        end else if (enFall || state == IDLE) begin
            bitCnt  <= 3'd0;
            rxShift <= 7'd0;
            txShift <= 8'd0;
        end else begin
            if (sckRise) begin
                rxShift <= {rxShift[5:0], mosiS};
                bitCnt  <= bitCnt + 3'd1;
            end
            if (byteDone) begin
                if (state == CMD) begin
                    rwFlag <= rxShift[6];
                    aiFlag <= rxShift[5];
                    addr   <= {rxShift[4:0], mosiS};
                end else if (aiFlag) begin
                    addr <= addr + 6'd1;
                end
            end
            if (txLoad) begin
                txShift <= rdData;
            end else if (txShiftEn) begin
                txShift <= {txShift[6:0], 1'b0};
            end
        end
    end

    // Read-data mux, interrupt set/clear masks and pad packing
    always_comb begin
        rdData  = 8'h00;
        intfAny = 1'b0;
        pin_out = '0;
        pin_oe  = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            setEv[p]   = (pinS[8*p +: 8] ^ pinPrev[8*p +: 8]) & ienReg[p];
            clrMask[p] = (wrEn && portSel == 3'(p) && offSel == 3'd4) ? wrData : 8'h00;
            intfAny    = intfAny | (|intfReg[p]);
            pin_out[8*p +: 8] = outReg[p];
            pin_oe[8*p +: 8]  = dirReg[p];
            if (portSel == 3'(p)) begin
                case (offSel)
                    3'd0:    rdData = dirReg[p];
                    3'd1:    rdData = outReg[p];
                    3'd2:    rdData = pinS[8*p +: 8];
                    3'd3:    rdData = ienReg[p];
                    3'd4:    rdData = intfReg[p];
                    default: rdData = 8'h00;
                endcase
            end
        end
    end

    // Port register file; interrupt set beats a coincident W1C clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                dirReg[p]  <= 8'h00;
                outReg[p]  <= 8'h00;
                ienReg[p]  <= 8'h00;
                intfReg[p] <= 8'h00;
            end
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (wrEn && portSel == 3'(p)) begin
                    case (offSel)
                        3'd0:    dirReg[p] <= wrData;
                        3'd1:    outReg[p] <= wrData;
                        3'd3:    ienReg[p] <= wrData;
                        default: ;
                    endcase
                end
                intfReg[p] <= (intfReg[p] & ~clrMask[p]) | setEv[p];
            end
        end
    end

    // Registered interrupt output
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq <= 1'b0;
        end else begin
            irq <= intfAny;
        end
    end

endmodule

// File: doc/spi_io_expander_n.md
Name: spi_io_expander_n

Overview:
Parametrised successor to the 32-line SPI I/O expander. It provides NUM_PORTS 8-bit GPIO ports behind an SPI mode-0 slave running in the single system clock domain. SCK, EN and MOSI are oversampled. New features:
- per-port direction, output and interrupt-enable registers
- sticky, W1C interrupt flags with a combined irq output
- auto-increment burst access
Pads connect through separate in/out/oe vectors at the top level.

Parameters:
NUM_PORTS, 4, number of 8-bit ports; legal 1..8
SYNC_STAGES, 2, synchroniser depth for sck/en/mosi/pin_in; legal 2..3

Ports:
clk  in  1  system clock; SCK frequency must be ≤ clk/8
rst  in  1  asynchronous, active-high reset
sck  in  1  SPI serial clock (mode 0, CPOL=0, CPHA=0)
en  in  1  SPI frame enable, active-high; high = transaction in progress
mosi  in  1  serial data in, MSB first
miso  out  1  serial data out, MSB first; 0 when not driving read data
pin_in  in  8*NUM_PORTS  pad input values
pin_out  out  8*NUM_PORTS  pad output values (= OUT registers)
pin_oe  out  8*NUM_PORTS  pad output enables (= DIR registers, 1=output)
irq  out  1  OR of all INTF bits

Behaviour:
- Reset: every register, synchroniser, FSM and output goes to 0. This covers miso, irq, pin_out, pin_oe, DIR, OUT, IEN, INTF, bit counter and address. FSM enters IDLE.
- Synchronisation: sck, en and mosi pass through SYNC_STAGES flops. One further register provides edge detect. Rise/fall pulses are 1 clk wide, SYNC_STAGES+1 clk after the pad edge.
- Register map: address = port*8 + offset.
  - offset 0: DIR, RW
  - offset 1: OUT, RW
  - offset 2: IN, RO; returns synchronised pin_in
  - offset 3: IEN, RW
  - offset 4: INTF, W1C
  - offsets 5-7 and ports ≥ NUM_PORTS: read 0x00, writes ignored
- Command byte: bit7 = R/W (1 = read), bit6 = AI (auto-increment), bits5:0 = start address.
- FSM:
  - IDLE → CMD on en rising.
  - CMD: bit counter counts sck rising edges. On the 8th edge, latch addr and the rw/ai flags, then go to DATA.
  - DATA: each group of 8 sck rising edges is one byte.
    - Write: on the 8th rising edge, commit the byte to addr. The register updates 1 clk after the rise pulse.
    - Read: no register side effects.
    - After each byte, if AI=1, addr = (addr + 1) mod 64; if AI=0, addr holds. Reserved addresses are traversed normally.
  - Any state → IDLE on en falling. A partial byte is discarded with no write. miso returns to 0 on the same clk.
- miso (read only):
  - On the sck falling pulse that follows each completed byte while rw=1, the tx shift register loads read data from the current addr. This includes the falling edge right after the command byte. MSB appears on miso the same clk.
  - The other 7 falling pulses in the byte shift left.
  - miso stays 0 during the command byte and for whole write frames.
- Interrupts:
  - The previous synchronised input is registered. A change on bit b with IEN bit b = 1 sets INTF bit b, independent of DIR.
  - A W1C write clears the written 1-bits. If a set event and a clear hit the same bit in the same clk, set wins.
  - irq is registered, 1 clk after INTF changes.
- pin_out = OUT and pin_oe = DIR, combinational from the registers.
- en rising mid-frame is impossible by definition. An en low→high glitch shorter than SYNC_STAGES clk may be missed; this is legal.

Test Plan:
- Reset values: after rst pulse → pin_oe=0, pin_out=0, irq=0, miso=0; reading addr 0x00..0x04 of every port returns 00,00,pin_in,00,00.
- Single write: frame 0x08,0xA5 (write port1 DIR), then 0x09,0x3C → pin_oe[15:8]=0xA5 and pin_out[15:8]=0x3C, each within SYNC_STAGES+2 clk of the 8th sck rise. Other ports unchanged.
- AI burst read: set pin_in[7:0]=0x5A. Send 0xC0 then 4 dummy bytes → miso bytes 00,00,5A,00 (DIR, OUT, IN, IEN of port 0). Repeat with 0x80 (AI=0) → all four bytes 0x00.
- Wrap: NUM_PORTS=8, AI write starting at 0x3F with 2 bytes 0x11,0x22 → addr 0x3F ignored (reserved), port0 DIR=0x22.
- Interrupt: IEN port2=0x01, toggle pin_in[16] → INTF2=0x01, irq=1. Write 0xFF to 0x14 → irq=0. Toggle again in the same clk as the W1C commit → INTF2 stays 0x01.
- Abort/reset: drop en after 5 bits of a data byte → no register change. Assert rst mid-frame → all outputs 0 immediately. The next full frame works normally.
